// File: rtl/nn_fixed_pkg.sv
// nn_fixed_pkg: Q6.9 fixed-point constants and neuron FSM states shared by the accumulator and sigmoid stages
package nn_fixed_pkg;
  localparam int DATA_W = 16;
  localparam int FRAC = 9;
  localparam logic [DATA_W-1:0] ONE = 16'h0200;
  localparam logic [DATA_W-1:0] SAT_MAX = 16'h7FFF;
  localparam logic [DATA_W-1:0] SAT_MIN = 16'h8000;
  typedef enum logic [1:0] {FIRST, ACC, ROUND, OUT} state_t;
endpackage

// File: rtl/fx_round_sat.sv
// fx_round_sat: round half toward +inf, arithmetic shift right by FRAC, saturate IN_W to OUT_W with clamp flag
module fx_round_sat #(
  parameter int IN_W = 40,
  parameter int OUT_W = 16,
  parameter int FRAC = 9
) (
  input  logic signed [IN_W-1:0]  i_x,
  output logic signed [OUT_W-1:0] o_y,
  output logic                    o_sat
);
  localparam logic signed [IN_W:0] HALF = (IN_W+1)'(1) << (FRAC - 1);
  localparam logic signed [IN_W:0] MAXV = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W:0] MINV = ~MAXV;
  logic signed [IN_W:0] w_sum, w_shr;
  logic w_hi, w_lo;
  // one guard bit so adding the half LSB can never wrap
  assign w_sum = $signed({i_x[IN_W-1], i_x}) + HALF;
  assign w_shr = w_sum >>> FRAC;
  assign w_hi = w_shr > MAXV;
  assign w_lo = w_shr < MINV;
  assign o_sat = w_hi || w_lo;
  assign o_y = w_hi ? {1'b0, {(OUT_W-1){1'b1}}} : w_lo ? {1'b1, {(OUT_W-1){1'b0}}} : w_shr[OUT_W-1:0];
endmodule

// File: rtl/neuron_acc_quant.sv
// neuron_acc_quant: bias + dot-product accumulator per neuron, rounded and saturated to Q6.9 for the sigmoid stage
module neuron_acc_quant
  import nn_fixed_pkg::*;
#(
  parameter int ACC_W = 40,
  parameter int MAX_LEN = 1024,
  localparam int LEN_W = $clog2(MAX_LEN + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_a,
  input  logic signed [DATA_W-1:0] in_w,
  input  logic signed [DATA_W-1:0] in_bias,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_x,
  output logic                     out_sat,
  output logic [LEN_W-1:0]         out_len,
  output logic                     err_len
);
  if (ACC_W < 2*DATA_W + $clog2(MAX_LEN) + 1) begin : g_acc_w_chk
    $error("ACC_W too narrow for MAX_LEN beats");
  end
  state_t r_state, w_state_nxt;
  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0] w_bias, w_acc_nxt, r_acc;
  logic [LEN_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc, r_len;
  logic signed [DATA_W-1:0] w_x, r_x;
  logic w_fire, w_hit, w_err_nxt, r_err, w_sat, r_sat;
  assign in_ready = (r_state == FIRST) || (r_state == ACC);
  assign w_fire = in_valid && in_ready;
  assign w_prod = in_a * in_w;
  assign w_bias = ACC_W'(in_bias) <<< FRAC;
  assign w_cnt_inc = (r_state == FIRST) ? LEN_W'(1) : r_cnt + 1'b1;
  assign w_hit = w_cnt_inc == LEN_W'(MAX_LEN);
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt = r_acc;
    w_cnt_nxt = r_cnt;
    w_err_nxt = r_err;
    case (r_state)
      FIRST, ACC: if (w_fire) begin
        w_acc_nxt = ((r_state == FIRST) ? w_bias : r_acc) + ACC_W'(w_prod);
        w_cnt_nxt = w_cnt_inc;
        w_state_nxt = (in_last || w_hit) ? ROUND : ACC;
        // hitting the length cap without in_last forces the neuron closed
        w_err_nxt = r_err || (w_hit && !in_last);
      end
      ROUND: w_state_nxt = OUT;
      default: if (out_ready) begin
        w_state_nxt = FIRST;
        w_acc_nxt = '0;
        w_cnt_nxt = '0;
      end
    endcase
  end
  fx_round_sat #(.IN_W(ACC_W), .OUT_W(DATA_W), .FRAC(FRAC)) u_round (
    .i_x(r_acc),
    .o_y(w_x),
    .o_sat(w_sat)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= FIRST;
      r_acc <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
      r_x <= '0;
      r_sat <= 1'b0;
      r_len <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_acc <= w_acc_nxt;
      r_cnt <= w_cnt_nxt;
      r_err <= w_err_nxt;
      if (r_state == ROUND) begin
        r_x <= w_x;
        r_sat <= w_sat;
        r_len <= r_cnt;
      end
    end
  end
  assign out_valid = r_state == OUT;
  assign out_x = r_x;
  assign out_sat = r_sat;
  assign out_len = r_len;
  assign err_len = r_err;
endmodule

// File: tb/tb_neuron_acc_quant.sv
// tb_neuron_acc_quant: directed vectors with hand-computed Q6.9 results, MAX_LEN shrunk to 4 for the length cap
module tb_neuron_acc_quant;
  logic clk = 1'b0, rst = 1'b0, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [15:0] in_a = '0, in_w = '0, in_bias = '0;
  logic in_ready, out_valid, out_sat, err_len;
  logic [15:0] out_x;
  logic [2:0] out_len;
  int vecs = 0, errs = 0;

  always #5 clk = ~clk;

  neuron_acc_quant #(.ACC_W(40), .MAX_LEN(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_w(in_w), .in_bias(in_bias), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x),
    .out_sat(out_sat), .out_len(out_len), .err_len(err_len)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] w, input logic [15:0] b, input logic last);
    int n = 0;
    in_a = a; in_w = w; in_bias = b; in_last = last; in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 20) begin tick; n++; end
    if (in_ready !== 1'b1) begin
      vecs++; errs++;
      $display("FAIL send_timeout in_ready=%b want 1", in_ready);
    end
    tick;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_out;
    int n = 0;
    while (out_valid !== 1'b1 && n < 20) begin tick; n++; end
    if (out_valid !== 1'b1) begin
      vecs++; errs++;
      $display("FAIL out_timeout out_valid=%b want 1", out_valid);
    end
  endtask

  task automatic pop;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) tick;
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rst_valid got %b want 0", out_valid); end
    vecs++; if (out_x !== 16'h0000) begin errs++; $display("FAIL rst_x got %h want 0000", out_x); end
    vecs++; if (out_sat !== 1'b0) begin errs++; $display("FAIL rst_sat got %b want 0", out_sat); end
    vecs++; if (out_len !== 3'd0) begin errs++; $display("FAIL rst_len got %0d want 0", out_len); end
    vecs++; if (err_len !== 1'b0) begin errs++; $display("FAIL rst_err got %b want 0", err_len); end
    rst = 1'b1;
    tick;
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL rst_ready got %b want 1", in_ready); end
  endtask

  task automatic test_basic;
    send(16'h0200, 16'h0200, 16'h0000, 1'b1);
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL basic_early got %b want 0", out_valid); end
    tick;
    vecs++; if (out_valid !== 1'b1) begin errs++; $display("FAIL basic_latency got %b want 1", out_valid); end
    vecs++; if (out_x !== 16'h0200) begin errs++; $display("FAIL basic_x got %h want 0200", out_x); end
    vecs++; if (out_sat !== 1'b0) begin errs++; $display("FAIL basic_sat got %b want 0", out_sat); end
    vecs++; if (out_len !== 3'd1) begin errs++; $display("FAIL basic_len got %0d want 1", out_len); end
    pop;
  endtask

  task automatic test_bias;
    send(16'h0000, 16'h1234, 16'h0548, 1'b0);
    send(16'h0000, 16'h1234, 16'h7FFF, 1'b0);
    send(16'h0000, 16'h1234, 16'h7FFF, 1'b1);
    wait_out;
    vecs++; if (out_x !== 16'h0548) begin errs++; $display("FAIL bias_x got %h want 0548", out_x); end
    vecs++; if (out_len !== 3'd3) begin errs++; $display("FAIL bias_len got %0d want 3", out_len); end
    pop;
  endtask

  task automatic test_rounding;
    send(16'hFFFF, 16'h0100, 16'h0000, 1'b1);
    wait_out;
    vecs++; if (out_x !== 16'h0000) begin errs++; $display("FAIL rnd_neg_half got %h want 0000", out_x); end
    pop;
    send(16'h0001, 16'h0100, 16'h0000, 1'b1);
    wait_out;
    vecs++; if (out_x !== 16'h0001) begin errs++; $display("FAIL rnd_pos_half got %h want 0001", out_x); end
    pop;
    send(16'hFFFF, 16'h0101, 16'h0000, 1'b1);
    wait_out;
    vecs++; if (out_x !== 16'hFFFF) begin errs++; $display("FAIL rnd_neg_over got %h want ffff", out_x); end
    vecs++; if (out_sat !== 1'b0) begin errs++; $display("FAIL rnd_sat got %b want 0", out_sat); end
    pop;
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 4; i++) send(16'h7FFF, 16'h7FFF, 16'h0000, i == 3);
    wait_out;
    vecs++; if (out_x !== 16'h7FFF) begin errs++; $display("FAIL sat_pos_x got %h want 7fff", out_x); end
    vecs++; if (out_sat !== 1'b1) begin errs++; $display("FAIL sat_pos_flag got %b want 1", out_sat); end
    vecs++; if (out_len !== 3'd4) begin errs++; $display("FAIL sat_pos_len got %0d want 4", out_len); end
    pop;
    for (int i = 0; i < 4; i++) send(16'h8000, 16'h7FFF, 16'h0000, i == 3);
    wait_out;
    vecs++; if (out_x !== 16'h8000) begin errs++; $display("FAIL sat_neg_x got %h want 8000", out_x); end
    vecs++; if (out_sat !== 1'b1) begin errs++; $display("FAIL sat_neg_flag got %b want 1", out_sat); end
    pop;
  endtask

  task automatic test_back_pressure;
    send(16'h0200, 16'h0400, 16'h0100, 1'b1);
    wait_out;
    in_a = 16'h0200; in_w = 16'h0200; in_bias = 16'h0000; in_last = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      vecs++; if (out_valid !== 1'b1) begin errs++; $display("FAIL bp_valid[%0d] got %b want 1", i, out_valid); end
      vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL bp_ready[%0d] got %b want 0", i, in_ready); end
      vecs++; if (out_x !== 16'h0500) begin errs++; $display("FAIL bp_x[%0d] got %h want 0500", i, out_x); end
    end
    pop;
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL bp_resume got %b want 1", in_ready); end
    tick;
    in_valid = 1'b0; in_last = 1'b0;
    wait_out;
    vecs++; if (out_x !== 16'h0200) begin errs++; $display("FAIL bp_next_x got %h want 0200", out_x); end
    vecs++; if (out_len !== 3'd1) begin errs++; $display("FAIL bp_next_len got %0d want 1", out_len); end
    pop;
  endtask

  task automatic test_err_len;
    for (int i = 0; i < 4; i++) send(16'h0200, 16'h0200, 16'h0000, 1'b0);
    vecs++; if (err_len !== 1'b1) begin errs++; $display("FAIL err_set got %b want 1", err_len); end
    wait_out;
    vecs++; if (out_x !== 16'h0800) begin errs++; $display("FAIL err_x got %h want 0800", out_x); end
    vecs++; if (out_len !== 3'd4) begin errs++; $display("FAIL err_len_cnt got %0d want 4", out_len); end
    pop;
    send(16'h0200, 16'h0200, 16'h0200, 1'b1);
    wait_out;
    vecs++; if (out_x !== 16'h0400) begin errs++; $display("FAIL err_next_x got %h want 0400", out_x); end
    vecs++; if (out_len !== 3'd1) begin errs++; $display("FAIL err_next_len got %0d want 1", out_len); end
    vecs++; if (err_len !== 1'b1) begin errs++; $display("FAIL err_sticky got %b want 1", err_len); end
    pop;
  endtask

  task automatic test_reset_mid;
    send(16'h0200, 16'h0200, 16'h0000, 1'b0);
    send(16'h0200, 16'h0200, 16'h0000, 1'b0);
    #2 rst = 1'b0;
    #2 rst = 1'b1;
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL rmid_ready got %b want 1", in_ready); end
    vecs++; if (err_len !== 1'b0) begin errs++; $display("FAIL rmid_err got %b want 0", err_len); end
    repeat (3) tick;
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rmid_valid got %b want 0", out_valid); end
    send(16'h0200, 16'h0200, 16'h0000, 1'b1);
    wait_out;
    vecs++; if (out_x !== 16'h0200) begin errs++; $display("FAIL rmid_x got %h want 0200", out_x); end
    vecs++; if (out_len !== 3'd1) begin errs++; $display("FAIL rmid_len got %0d want 1", out_len); end
    pop;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_bias;
    test_rounding;
    test_saturation;
    test_back_pressure;
    test_err_len;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
